// File: rtl/io_bus_pkg.sv
// Shared io_bus types: address/data words and arbiter states.
// Used by the arbiter, its interface and io_bus memory users.
package io_bus_pkg;

  localparam int IO_ADDR_W = 9;
  localparam int IO_DATA_W = 64;

  typedef logic [0:IO_ADDR_W-1] io_addr_t;
  typedef logic [0:IO_DATA_W-1] io_data_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } io_arb_state_e;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester handshakes plus io_bus address/data port.
// slave = arbiter side, master = requesters and io_bus.
interface io_bus_arbiter_if
  import io_bus_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic     [0:NUM_REQ-1] req_valid;
  io_addr_t [0:NUM_REQ-1] req_addr;
  io_data_t [0:NUM_REQ-1] req_wdata;
  logic     [0:NUM_REQ-1] req_we;
  logic     [0:NUM_REQ-1] req_lock;
  logic     [0:NUM_REQ-1] req_ready;
  logic     [0:NUM_REQ-1] rsp_valid;
  io_data_t               rsp_data;
  logic     [0:NUM_REQ-1] rsp_ready;
  io_addr_t               bus_addr;
  io_data_t               bus_write_data;
  logic                   bus_write_enable;
  io_data_t               bus_read_data;

  modport slave (
    input  req_valid, req_addr, req_wdata,
    input  req_we, req_lock, rsp_ready,
    input  bus_read_data,
    output req_ready, rsp_valid, rsp_data,
    output bus_addr, bus_write_data,
    output bus_write_enable
  );

  modport master (
    output req_valid, req_addr, req_wdata,
    output req_we, req_lock, rsp_ready,
    output bus_read_data,
    input  req_ready, rsp_valid, rsp_data,
    input  bus_addr, bus_write_data,
    input  bus_write_enable
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first valid index after last,
// searching upward and wrapping modulo N.
module rr_picker #(
  parameter int N = 3
) (
  input  logic [0:N-1]         valid,
  input  logic [$clog2(N)-1:0] last,
  output logic [0:N-1]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  // scan N slots starting just after last
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = last;
    any     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any && valid[idx]) begin
        any     = 1'b1;
        gnt_idx = W'(idx);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (gnt_idx == W'(i));
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin io_bus arbiter, one transaction in flight.
// Optional lock for atomic RMW: define IO_ARB_LOCK_EN.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input logic             clk,
  input logic             rst,
  io_bus_arbiter_if.slave ifc
);

  localparam int IW = $clog2(NUM_REQ);

  io_arb_state_e      state;
  logic [IW-1:0]      last_grant;
  io_addr_t           addr_q;
  io_data_t           wdata_q;
  logic               we_q;
  io_data_t           rsp_data_q;
  logic [0:NUM_REQ-1] rsp_valid_q;
  logic [0:NUM_REQ-1] last_oh;
  logic [0:NUM_REQ-1] pick_valid;
  logic [0:NUM_REQ-1] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any;

`ifdef IO_ARB_LOCK_EN
  logic          lock_q;
  logic          lock_active;
  logic [IW-1:0] lock_owner;

  // while locked only the owner may win
  always_comb begin
    pick_valid = ifc.req_valid;
    if (lock_active) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pick_valid[i] = ifc.req_valid[i] &&
                        (lock_owner == IW'(i));
      end
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^ifc.req_lock;
  assign pick_valid  = ifc.req_valid;
`endif

  rr_picker #(
    .N(NUM_REQ)
  ) u_pick (
    .valid   (pick_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // one-hot of the current grant for the response
  always_comb begin
    last_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      last_oh[i] = (last_grant == IW'(i));
    end
  end

  assign ifc.req_ready = (state == IDLE) ? gnt : '0;
  assign ifc.rsp_valid = rsp_valid_q;
  assign ifc.rsp_data  = rsp_data_q;
  assign ifc.bus_addr  = addr_q;
  assign ifc.bus_write_data = wdata_q;
  assign ifc.bus_write_enable =
    (state == ACCESS) && we_q && !rst;

  // IDLE -> ACCESS -> RESP -> IDLE transaction FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
`ifdef IO_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            addr_q     <= ifc.req_addr[gnt_idx];
            wdata_q    <= ifc.req_wdata[gnt_idx];
            we_q       <= ifc.req_we[gnt_idx];
            last_grant <= gnt_idx;
`ifdef IO_ARB_LOCK_EN
            lock_q     <= ifc.req_lock[gnt_idx];
`endif
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_data_q  <= we_q ? '0 : ifc.bus_read_data;
          rsp_valid_q <= last_oh;
          state       <= RESP;
        end
        RESP: begin
          if (ifc.rsp_ready[last_grant]) begin
            rsp_valid_q <= '0;
            state       <= IDLE;
`ifdef IO_ARB_LOCK_EN
            lock_active <= lock_q;
            lock_owner  <= last_grant;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter against a
// transaction-level round-robin model.
module tb_io_bus_arbiter;

  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.NUM_REQ(NR)) ifc ();

  io_bus_arbiter #(.NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  logic [63:0] mem     [0:511];
  logic [63:0] ref_mem [0:511];

  assign ifc.bus_read_data = mem[ifc.bus_addr];

  always @(posedge clk)
    if (ifc.bus_write_enable)
      mem[ifc.bus_addr] <= ifc.bus_write_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          g;
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  bit          hold [NR];
  logic [8:0]  a_r  [NR];
  logic [63:0] d_r  [NR];
  bit          we_r [NR];
  bit          lk_r [NR];
  bit          seen_rdy [NR];
  int          p_rdy [NR];
  int          p_req  = 0;
  int          p_we   = 50;
  int          p_lock = 0;

  bit          busy = 0;
  int          cur_g, acc_cyc;
  logic [8:0]  cur_a;
  logic [63:0] cur_d;
  bit          cur_we, cur_lk;
  int          ref_last   = NR - 1;
  int          lock_owner = -1;
  bit          fair_chk   = 0;
  int          fair_last  = -1;
  int          fair_g     = -1;
  bit          in_rsp     = 0;

  function void chk(string n, logic [63:0] act,
                    logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endfunction

  function automatic logic [8:0] rand_addr();
    int a;
    a = $urandom_range(0, 31);
    return (a >= 16) ? 9'(256 + a - 16) : 9'(a);
  endfunction

  function void apply();
    for (int i = 0; i < NR; i++) begin
      ifc.req_valid[i] = hold[i];
      ifc.req_addr[i]  = a_r[i];
      ifc.req_wdata[i] = d_r[i];
      ifc.req_we[i]    = we_r[i];
      ifc.req_lock[i]  = lk_r[i];
    end
  endfunction

  function bit hold_any();
    bit r;
    r = 0;
    for (int i = 0; i < NR; i++) r |= hold[i];
    return r;
  endfunction

  task automatic post(int i, logic [8:0] a,
                      logic [63:0] d, bit we, bit lk);
    hold[i] = 1;
    a_r[i]  = a;
    d_r[i]  = d;
    we_r[i] = we;
    lk_r[i] = lk;
    apply();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string n, int budget);
    int k;
    k = 0;
    while ((hold_any() || busy || in_rsp ||
            sbq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk(n, 64'(k < budget), 64'd1);
  endtask

  // requesters: hold until accepted, random consume
  always @(negedge clk)
    for (int i = 0; i < NR; i++)
      seen_rdy[i] = ifc.req_ready[i] && !rst;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (seen_rdy[i]) hold[i] = 0;
      if (!hold[i]) begin
        a_r[i]  = rand_addr();
        d_r[i]  = {$urandom, $urandom};
        we_r[i] = ($urandom_range(0, 99) < p_we);
        lk_r[i] = ($urandom_range(0, 99) < p_lock);
        if ($urandom_range(0, 99) < p_req) hold[i] = 1;
      end
      ifc.rsp_ready[i] = ($urandom_range(0, 99) < p_rdy[i]);
    end
    apply();
  end

  // reference model: predicts grants, bus cycle, data
  always @(negedge clk) begin : model
    logic [0:NR-1] v;
    logic [0:NR-1] exp_oh;
    bit            done;
    int            g;
    exp_t          e;
    if (rst) begin
      if (busy && cyc == acc_cyc + 1)
        chk("bwe_rst", 64'(ifc.bus_write_enable), 64'd0);
      busy       = 0;
      ref_last   = NR - 1;
      lock_owner = -1;
      sbq.delete();
    end else begin
      if (busy && cyc == acc_cyc + 1) begin
        chk("bus_addr", 64'(ifc.bus_addr), 64'(cur_a));
        chk("bus_we", 64'(ifc.bus_write_enable),
            64'(cur_we));
        if (cur_we) begin
          chk("bus_wdata", 64'(ifc.bus_write_data), cur_d);
          ref_mem[cur_a] = cur_d;
        end
      end else begin
        chk("bwe_idle", 64'(ifc.bus_write_enable), 64'd0);
      end
      done = busy && (cyc >= acc_cyc + 2) &&
             ifc.rsp_ready[cur_g];
`ifdef IO_ARB_LOCK_EN
      if (done) begin
        if (cur_lk) lock_owner = cur_g;
        else if (lock_owner == cur_g) lock_owner = -1;
      end
`endif
      exp_oh = '0;
      if (!busy) begin
        for (int i = 0; i < NR; i++) begin
          v[i] = hold[i];
          if (lock_owner >= 0 && i != lock_owner) v[i] = 0;
        end
        g = -1;
        for (int k = 1; k <= NR; k++)
          if (g < 0 && v[(ref_last + k) % NR])
            g = (ref_last + k) % NR;
        if (g >= 0) begin
          exp_oh[g] = 1'b1;
          cur_g   = g;
          cur_a   = a_r[g];
          cur_d   = d_r[g];
          cur_we  = we_r[g];
          cur_lk  = lk_r[g];
          acc_cyc = cyc;
          busy    = 1;
          e.g     = g;
          e.data  = cur_we ? 64'd0 : ref_mem[cur_a];
          e.acc   = cyc;
          sbq.push_back(e);
          if (fair_chk) begin
            if (fair_last >= 0) begin
              chk("fair_gap", 64'(cyc - fair_last), 64'd3);
              chk("fair_order", 64'(g),
                  64'((fair_g + 1) % NR));
            end
            fair_last = cyc;
            fair_g    = g;
          end
          ref_last = g;
        end
      end
      chk("req_ready", 64'(ifc.req_ready), 64'(exp_oh));
      if (done) busy = 0;
    end
  end

  // monitor: pops scoreboard when a response appears
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [0:NR-1] eo;
    logic [0:NR-1] h_v;
    logic [63:0]   h_d;
    if (rst) begin
      in_rsp = 0;
    end else if (ifc.rsp_valid != '0) begin
      if (!in_rsp) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected act=%b exp=000",
                   ifc.rsp_valid);
        end else begin
          e  = sbq.pop_front();
          eo = '0;
          eo[e.g] = 1'b1;
          chk("rsp_valid", 64'(ifc.rsp_valid), 64'(eo));
          chk("rsp_data", 64'(ifc.rsp_data), e.data);
          chk("rsp_lat", 64'(cyc - e.acc), 64'd2);
        end
        in_rsp = 1;
        h_v    = ifc.rsp_valid;
        h_d    = 64'(ifc.rsp_data);
      end else begin
        chk("rsp_hold_v", 64'(ifc.rsp_valid), 64'(h_v));
        chk("rsp_hold_d", 64'(ifc.rsp_data), h_d);
      end
      if ((ifc.rsp_valid & ifc.rsp_ready) != '0)
        in_rsp = 0;
    end else if (in_rsp) begin
      checks++;
      errors++;
      $display("FAIL rsp_dropped act=0 exp=%b", h_v);
      in_rsp = 0;
    end
  end

  initial begin : main
    int k;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < NR; i++) begin
      hold[i]  = 0;
      a_r[i]   = '0;
      d_r[i]   = '0;
      we_r[i]  = 0;
      lk_r[i]  = 0;
      p_rdy[i] = 100;
    end
    apply();
    ifc.rsp_ready = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ifc.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(ifc.rsp_data), 64'd0);
    chk("rst_bus_addr", 64'(ifc.bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(ifc.bus_write_data), 64'd0);
    chk("rst_bwe", 64'(ifc.bus_write_enable), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single read from req 1
    step();
    post(1, 9'h105, 64'd0, 0, 0);
    wait_idle("t1_idle", 20);

    // write then read back
    step();
    post(0, 9'h10A, 64'hDEADBEEF_0000_0001, 1, 0);
    wait_idle("t2w_idle", 20);
    step();
    post(0, 9'h10A, 64'd0, 0, 0);
    wait_idle("t2r_idle", 20);

    // fairness with everyone always valid
    p_lock    = 0;
    fair_last = -1;
    fair_chk  = 1;
    p_req     = 100;
    repeat (24) step();
    fair_chk = 0;
    p_req    = 0;
    wait_idle("t3_idle", 40);

    // response backpressure on req 0
    p_rdy[0] = 0;
    step();
    post(0, 9'h107, 64'd0, 0, 0);
    k = 0;
    while (!in_rsp && k < 10) begin
      step();
      k++;
    end
    chk("t4_rsp_seen", 64'(in_rsp), 64'd1);
    post(1, 9'h108, 64'd0, 0, 0);
    repeat (5) step();
    chk("t4_req1_wait", 64'(hold[1]), 64'd1);
    p_rdy[0] = 100;
    wait_idle("t4_idle", 30);

    // reset during ACCESS of a write
    step();
    post(0, 9'h100, 64'hA5A5_5A5A_0F0F_F0F0, 1, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ifc.req_ready[0] && k < 20);
    chk("t5_accept", 64'(ifc.req_ready[0]), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    post(0, 9'h100, 64'd0, 0, 0);
    post(1, 9'h100, 64'd0, 0, 0);
    wait_idle("t5_idle", 30);

`ifdef IO_ARB_LOCK_EN
    // locked RMW from req 2 holds off req 0
    step();
    post(2, 9'h103, 64'd0, 0, 1);
    wait_idle("t6a_idle", 20);
    step();
    post(0, 9'h104, 64'd0, 0, 0);
    post(2, 9'h105, 64'd0, 0, 1);
    k = 0;
    while ((hold[2] || busy) && k < 50) begin
      step();
      k++;
    end
    chk("t6_req0_blocked", 64'(hold[0]), 64'd1);
    post(2, 9'h103, 64'h1234, 1, 0);
    wait_idle("t6_idle", 40);
`endif

    // random traffic
    p_req  = 40;
    p_lock = 30;
    for (int i = 0; i < NR; i++) p_rdy[i] = 60;
    repeat (1500) step();
    p_lock = 0;
    repeat (200) step();
    p_req = 0;
    wait_idle("rand_idle", 2000);

    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
